// File: rtl/cpu_dma_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cpu_dma_pkg : state encoding, SIZE codes and default parameters for the DMA sequencer
// rev 1.0
// ----------------------------------------------------------------------------
package cpu_dma_pkg;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_REQ  = 4'd1,
    S_OWN  = 4'd2,
    S_ADDR = 4'd3,
    S_DATA = 4'd4,
    S_TERM = 4'd5,
    S_NEXT = 4'd6,
    S_REL  = 4'd7,
    S_ERR  = 4'd8
  } dma_state_t;

  localparam logic [1:0] C_SIZE_LONG = 2'b00;
  localparam logic [1:0] C_SIZE_WORD = 2'b10;

  localparam int C_DEF_BURST_LEN = 4;
  localparam int C_DEF_FIFO_AW   = 3;
  localparam int C_DEF_TIMEOUT   = 255;

  // Synchroniser bank bit order: {BG_, DSACK0_, DSACK1_, STERM_, BERR_}
  localparam int C_SYNC_W = 5;

endpackage
`default_nettype wire

// File: rtl/cpu_dma_sync.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cpu_dma_sync : two-flop synchroniser bank for active-low bus inputs (resets to 1)
// rev 1.0
// ----------------------------------------------------------------------------
module cpu_dma_sync #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta     <= '1;
      sync_out <= '1;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cpu_dma_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cpu_dma_seq : bus-tenure sequencer moving longwords between a DMA FIFO and memory
// rev 1.0
// ----------------------------------------------------------------------------
module cpu_dma_seq
  import cpu_dma_pkg::*;
#(
  parameter int BURST_LEN = C_DEF_BURST_LEN,
  parameter int FIFO_AW   = C_DEF_FIFO_AW,
  parameter int TIMEOUT   = C_DEF_TIMEOUT
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             DMAENA,
  input  logic             DMADIR,
  input  logic             FLUSHFIFO,
  input  logic [FIFO_AW:0] FIFO_LVL,
  input  logic             BG_,
  input  logic             DSACK0_,
  input  logic             DSACK1_,
  input  logic             STERM_,
  input  logic             BERR_,
  output logic             BR,
  output logic             BGACK,
  output logic             PAS,
  output logic             PDS,
  output logic             RW,
  output logic [1:0]       SIZE,
  output logic             INCFIFO,
  output logic             DECFIFO,
  output logic             INCADDR,
  output logic             STOPFLUSH,
  output logic             BERRINT,
  output logic             BUSY
);

  localparam int CW = $clog2(BURST_LEN) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  dma_state_t state, next_state;
  logic [CW-1:0] beat_cnt;
  logic [TW-1:0] timer;
  logic          half_word, half_next;

  logic [C_SYNC_W-1:0] sync_q;
  logic bg_s, dsack0_s, dsack1_s, sterm_s, berr_s;

  cpu_dma_sync #(.WIDTH(C_SYNC_W)) u_sync (
    .clk      (CLK),
    .rst      (RESET),
    .async_in ({BG_, DSACK0_, DSACK1_, STERM_, BERR_}),
    .sync_out (sync_q)
  );

  assign {bg_s, dsack0_s, dsack1_s, sterm_s, berr_s} = sync_q;

  int   fifo_free;
  logic start_ok, more_ok, long_done, word_done, term_idle, tmo_hit;

  assign fifo_free = (1 << FIFO_AW) - int'(FIFO_LVL);
  assign start_ok  = DMAENA && (DMADIR ? (int'(FIFO_LVL) >= BURST_LEN || (FLUSHFIFO && FIFO_LVL != '0))
                                       : (fifo_free >= BURST_LEN));
  assign more_ok   = DMADIR ? (FIFO_LVL != '0) : (fifo_free > 0);
  assign long_done = !sterm_s || (!dsack0_s && !dsack1_s);
  assign word_done = !dsack1_s && dsack0_s;
  assign term_idle = sterm_s && dsack0_s && dsack1_s;
  assign tmo_hit   = int'(timer) == TIMEOUT - 1;

  // Bus error wins over any termination sampled in the same cycle.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (start_ok) next_state = S_REQ;
      S_REQ:  if (!DMAENA) next_state = S_IDLE;
              else if (!bg_s) next_state = S_OWN;
      S_OWN:  next_state = S_ADDR;
      // Hold the address phase until the previous cycle's termination has negated.
      S_ADDR: if (!berr_s) next_state = S_ERR;
              else if (term_idle) next_state = S_DATA;
      S_DATA: if (!berr_s) next_state = S_ERR;
              else if (long_done) next_state = S_TERM;
              else if (word_done) next_state = half_word ? S_TERM : S_ADDR;
              else if (tmo_hit) next_state = S_ERR;
      S_TERM: next_state = S_NEXT;
      S_NEXT: if (int'(beat_cnt) < BURST_LEN && more_ok && DMAENA) next_state = S_ADDR;
              else next_state = S_REL;
      S_REL:  next_state = S_IDLE;
      S_ERR:  next_state = S_REL;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    half_next = half_word;
    if (next_state == S_OWN || next_state == S_TERM) half_next = 1'b0;
    else if (state == S_DATA && next_state == S_ADDR) half_next = 1'b1;
  end

  // Outputs are decoded from the next state and registered, so they line up with state.
  logic       br_d, bgack_d, pas_d, pds_d, rw_d, inc_d, dec_d, adr_d, stop_d, berr_d;
  logic [1:0] size_d;

  always_comb begin
    br_d    = (next_state == S_REQ);
    bgack_d = next_state inside {S_OWN, S_ADDR, S_DATA, S_TERM, S_NEXT, S_ERR};
    pas_d   = next_state inside {S_ADDR, S_DATA};
    pds_d   = (next_state == S_DATA);
    rw_d    = pas_d && !DMADIR;
    size_d  = (pas_d && half_next) ? C_SIZE_WORD : C_SIZE_LONG;
    inc_d   = (next_state == S_TERM) && !DMADIR;
    dec_d   = (next_state == S_TERM) && DMADIR;
    adr_d   = (next_state == S_TERM);
    stop_d  = FLUSHFIFO && DMADIR && (FIFO_LVL == '0);
    berr_d  = (next_state == S_ERR) || (BERRINT && DMAENA);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= S_IDLE;
      beat_cnt  <= '0;
      timer     <= '0;
      half_word <= 1'b0;
      BR        <= 1'b0;
      BGACK     <= 1'b0;
      PAS       <= 1'b0;
      PDS       <= 1'b0;
      RW        <= 1'b0;
      SIZE      <= C_SIZE_LONG;
      INCFIFO   <= 1'b0;
      DECFIFO   <= 1'b0;
      INCADDR   <= 1'b0;
      STOPFLUSH <= 1'b0;
      BERRINT   <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      state     <= next_state;
      half_word <= half_next;
      if (state == S_OWN) beat_cnt <= '0;
      else if (state == S_TERM && int'(beat_cnt) < BURST_LEN) beat_cnt <= beat_cnt + 1'b1;
      if (state != S_DATA) timer <= '0;
      else timer <= timer + 1'b1;
      BR        <= br_d;
      BGACK     <= bgack_d;
      PAS       <= pas_d;
      PDS       <= pds_d;
      RW        <= rw_d;
      SIZE      <= size_d;
      INCFIFO   <= inc_d;
      DECFIFO   <= dec_d;
      INCADDR   <= adr_d;
      STOPFLUSH <= stop_d;
      BERRINT   <= berr_d;
      BUSY      <= bgack_d;
    end
  end

endmodule
`default_nettype wire
